fetch_queue_stage: RTL and testbench

- Parametrised successor to the single-register fetch stage: owns the fetch PC, issues instruction-memory requests over a valid/ready handshake, and buffers returned instructions with their PCs in a QDEPTH-entry in-order queue.
- Presents instructions to decode over a valid/ready handshake.
- Supports stall (decode back-pressure, memory back-pressure, multi-cycle memory latency) and flush/redirect, with stale in-flight responses discarded.

---
 rtl/fetch_queue_stage.sv | 184 ++++++++++++++++++
 tb/tb_fetch_queue_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
//
// Fetch stage with an in-order instruction queue. Owns the fetch PC, issues
// instruction-memory requests and buffers returned words with their PCs
// until decode takes them.
//
// Handshakes: a transfer happens on a rising clock edge when both valid and
// ready are high. Valid never depends on the ready of the same interface.
//
// A queue slot is allocated when a request is accepted, so the queue holds
// entries in three states: free, allocated-but-unfilled (request in flight)
// and filled. Responses return in request order and fill the oldest unfilled
// slot. After a flush, responses still owed to the discarded requests are
// counted in drop_cnt and thrown away when they arrive.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all queued/in-flight fetches, restart at redirect_pc
//   redirect_pc       restart PC (bits [1:0] ignored)
//   imem_req_*        request channel (valid/ready/addr)
//   imem_resp_*       response channel (valid/data), no back-pressure
//   out_*             decode channel (valid/ready/pc/inst)
//   occupancy         allocated queue entries (filled + in flight)
module fetch_queue_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               QDEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [XLEN-1:0]           redirect_pc,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [XLEN-1:0]           imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [XLEN-1:0]           imem_resp_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_inst,
    output logic [$clog2(QDEPTH):0]   occupancy
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] QD_SUM = (CW+1)'(QDEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] e_pc_q   [QDEPTH];
    logic [XLEN-1:0] e_pc_d   [QDEPTH];
    logic [XLEN-1:0] e_inst_q [QDEPTH];
    logic [XLEN-1:0] e_inst_d [QDEPTH];
    logic [QDEPTH-1:0] e_filled_q, e_filled_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   drop_q, drop_d;
    // Allocated-but-unfilled entries; always the slots from fill_q up to tail_q.
    logic [CW-1:0]   pend_q, pend_d;

    logic            req_fire;
    logic            pop;
    logic            fill_take;
    logic [CW:0]     outstanding;
    logic            unused_ok;

    // Low redirect bits are forced to zero, so they are intentionally unused.
    assign unused_ok = ^redirect_pc[1:0];

    // Gate uses registered count: a pop this cycle does not free a slot for a
    // request in the same cycle.
    assign imem_req_valid = !rst && !flush
                          && (({1'b0, count_q} + {1'b0, drop_q}) < QD_SUM);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid = e_filled_q[head_q];
    assign out_pc    = e_pc_q[head_q];
    assign out_inst  = e_inst_q[head_q];
    assign pop       = out_valid && out_ready;
    assign occupancy = count_q;

    // Responses still owed to the memory: for dropped and for live requests.
    assign outstanding = {1'b0, drop_q} + {1'b0, pend_q};

    always_comb begin
        pc_d       = pc_q;
        e_pc_d     = e_pc_q;
        e_inst_d   = e_inst_q;
        e_filled_d = e_filled_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        drop_d     = drop_q;
        pend_d     = pend_q;
        fill_take  = 1'b0;

        if (flush) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            for (int i = 0; i < QDEPTH; i++) begin
                e_pc_d[i]   = '0;
                e_inst_d[i] = '0;
            end
            e_filled_d = '0;
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            count_d    = '0;
            pend_d     = '0;
            // Every outstanding response becomes a drop, except one arriving
            // right now which is consumed by this cycle.
            if (imem_resp_valid && (outstanding != '0))
                drop_d = CW'(outstanding - (CW+1)'(1));
            else
                drop_d = CW'(outstanding);
        end else begin
            if (pop) begin
                e_pc_d[head_q]     = '0;
                e_inst_d[head_q]   = '0;
                e_filled_d[head_q] = 1'b0;
                head_d             = head_q + PW'(1);
            end
            if (req_fire) begin
                e_pc_d[tail_q]     = pc_q;
                e_inst_d[tail_q]   = '0;
                e_filled_d[tail_q] = 1'b0;
                tail_d             = tail_q + PW'(1);
                pc_d               = pc_q + XLEN'(4);
            end
            if (imem_resp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else if (pend_q != '0) begin
                    fill_take          = 1'b1;
                    e_inst_d[fill_q]   = imem_resp_data;
                    e_filled_d[fill_q] = 1'b1;
                    fill_d             = fill_q + PW'(1);
                end
            end
            count_d = count_q + CW'(req_fire) - CW'(pop);
            pend_d  = pend_q + CW'(req_fire) - CW'(fill_take);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            for (int i = 0; i < QDEPTH; i++) begin
                e_pc_q[i]   <= '0;
                e_inst_q[i] <= '0;
            end
            e_filled_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            pend_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            e_pc_q     <= e_pc_d;
            e_inst_q   <= e_inst_d;
            e_filled_q <= e_filled_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            pend_q     <= pend_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, count_q} + {1'b0, drop_q}) <= QD_SUM))
        else $error("count + drop_cnt exceeds queue depth");

    a_pend_le_count: assert property (@(posedge clk) disable iff (rst)
        (pend_q <= count_q))
        else $error("unfilled entries exceed allocated entries");

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed testbench for fetch_queue_stage (QDEPTH=4, RESET_PC=0x100).
// The instruction memory model returns {16'hDEAD, addr[15:0]} for each
// accepted request, in order, after a programmable latency.
module tb_fetch_queue_stage;

    localparam int XLEN = 32;
    localparam int QDEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h100;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic [2:0]  occupancy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 1;
    logic last_fire;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [XLEN-1:0] exp_q[$];

    fetch_queue_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .occupancy(occupancy)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {16'hDEAD, a[15:0]};
    endfunction

    // Advance one clock; the memory model sees the handshakes of the cycle
    // and drives the next response shortly after the edge.
    task automatic step();
        logic        fire, resp;
        logic [31:0] a, dummy_a;
        int          dummy_d;
        #1;
        fire = imem_req_valid && imem_req_ready;
        resp = imem_resp_valid;
        a    = imem_req_addr;
        @(posedge clk);
        cyc++;
        last_fire = fire;
        if (resp && mq_addr.size() > 0) begin
            dummy_a = mq_addr.pop_front();
            dummy_d = mq_due.pop_front();
        end
        if (fire) begin
            mq_addr.push_back(a);
            mq_due.push_back(cyc + lat - 1);
        end
        #1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(mq_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        step();
        rst = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;
        step(); step();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b exp 0", imem_req_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d exp 0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h exp 0", out_pc); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst: got %h exp 0", out_inst); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_release_valid: got %b exp 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL reset_release_addr: got %h exp 00000100", imem_req_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL stream_addr0: got %h exp 00000100", imem_req_addr); end
        step();
        checks++; if (imem_req_addr !== 32'h104) begin errors++; $display("FAIL stream_addr1: got %h exp 00000104", imem_req_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass: got %b exp 0", out_valid); end
        for (int i = 0; i < 5; i++) begin
            step();
            e = 32'h100 + 32'(4 * i);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, out_valid); end
            checks++; if (out_pc !== e) begin errors++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, out_pc, e); end
            checks++; if (out_inst !== mem_data(e)) begin errors++; $display("FAIL stream_inst[%0d]: got %h exp %h", i, out_inst, mem_data(e)); end
            checks++; if (imem_req_addr !== e + 32'h8) begin errors++; $display("FAIL stream_addr[%0d]: got %h exp %h", i, imem_req_addr, e + 32'h8); end
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        logic [31:0] e;
        do_reset();
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        flush = 1'b1; redirect_pc = 32'h0;
        step();
        flush = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (last_fire) n_acc++;
        end
        checks++; if (n_acc !== 4) begin errors++; $display("FAIL bp_accepts: got %0d exp 4", n_acc); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid_full: got %b exp 0", imem_req_valid); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy: got %0d exp 4", occupancy); end
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        out_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_full_pop_no_req: got %b exp 0", imem_req_valid); end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1 || out_pc !== e) begin errors++; $display("FAIL bp_pop[%0d]: got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc, e); end
            checks++; if (out_inst !== mem_data(e)) begin errors++; $display("FAIL bp_inst[%0d]: got %h exp %h", i, out_inst, mem_data(e)); end
            step();
            if (i == 0) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_resume: got v=%b addr=%h exp v=1 addr=00000010", imem_req_valid, imem_req_addr); end
            end
        end
    endtask

    task automatic test_flush_inflight();
        int n;
        do_reset();
        lat = 4; imem_req_ready = 1'b1; out_ready = 1'b1;
        step(); step(); step();
        checks++; if (occupancy !== 3'd3 || out_valid !== 1'b0) begin errors++; $display("FAIL fl_pre: got occ=%0d v=%b exp occ=3 v=0", occupancy, out_valid); end
        flush = 1'b1; redirect_pc = 32'h203;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fl_req_during_flush: got %b exp 0", imem_req_valid); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL fl_redirect: got v=%b addr=%h exp v=1 addr=00000200", imem_req_valid, imem_req_addr); end
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fl_cleared: got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid); end
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fl_timeout: got no output after %0d cycles exp output", n); end
        checks++; if (out_pc !== 32'h200 || out_inst !== 32'hDEAD_0200) begin errors++; $display("FAIL fl_first_out: got pc=%h inst=%h exp pc=00000200 inst=dead0200", out_pc, out_inst); end
    endtask

    task automatic test_flush_same_cycle();
        int n;
        do_reset();
        lat = 2; imem_req_ready = 1'b1; out_ready = 1'b1;
        step(); step(); step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL fsc_pre: got v=%b pc=%h exp v=1 pc=00000100", out_valid, out_pc); end
        flush = 1'b1; redirect_pc = 32'h300;
        step();
        flush = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL fsc_cleared: got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin errors++; $display("FAIL fsc_redirect: got v=%b addr=%h exp v=1 addr=00000300", imem_req_valid, imem_req_addr); end
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fsc_timeout: got no output after %0d cycles exp output", n); end
        checks++; if (out_pc !== 32'h300 || out_inst !== 32'hDEAD_0300) begin errors++; $display("FAIL fsc_first_out: got pc=%h inst=%h exp pc=00000300 inst=dead0300", out_pc, out_inst); end
    endtask

    task automatic test_ready_toggle();
        logic [31:0] exp_addr, exp_pc;
        int pops;
        do_reset();
        lat = 1; out_ready = 1'b1;
        exp_addr = 32'h100; exp_pc = 32'h100; pops = 0;
        for (int i = 0; i < 20; i++) begin
            imem_req_ready = (i % 2 == 0);
            #1;
            checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL tog_addr[%0d]: got %h exp %h", i, imem_req_addr, exp_addr); end
            if (out_valid) begin
                checks++; if (out_pc !== exp_pc || out_inst !== mem_data(exp_pc)) begin errors++; $display("FAIL tog_out[%0d]: got pc=%h inst=%h exp pc=%h inst=%h", i, out_pc, out_inst, exp_pc, mem_data(exp_pc)); end
                exp_pc = exp_pc + 32'h4;
                pops++;
            end
            if (imem_req_valid && imem_req_ready) exp_addr = exp_addr + 32'h4;
            step();
        end
        checks++; if (pops !== 9) begin errors++; $display("FAIL tog_pops: got %0d exp 9", pops); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        lat = 2; imem_req_ready = 1'b1; out_ready = 1'b0;
        step(); step(); step();
        imem_req_ready = 1'b0;
        step();
        checks++; if (occupancy !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre: got occ=%0d v=%b exp occ=3 v=1", occupancy, out_valid); end
        imem_req_ready = 1'b1;
        do_reset();
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL rm_cleared: got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL rm_addr: got v=%b addr=%h exp v=1 addr=00000100", imem_req_valid, imem_req_addr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rm_out_pc: got %h exp 0", out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_inflight();
        test_flush_same_cycle();
        test_ready_toggle();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
